// File: rtl/nnet_sched_pkg.sv
// Shared types and constants for the NN vector admission scheduler.
package nnet_sched_pkg;

  // Input-side vector framing state
  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int MAX_INFLIGHT_DEF = 3;
  localparam int INF_W            = $clog2(MAX_INFLIGHT_DEF + 1);

  // Bit positions of the sticky error flags in the status register
  localparam int ERR_HANG  = 0;
  localparam int ERR_LEN   = 1;
  localparam int ERR_PROTO = 2;
  localparam int ERR_W     = 3;

endpackage

// File: rtl/nnet_vector_scheduler_if.sv
// AXI-Stream style handshake bundle used on the scheduler's input,
// output and snoop ports.
interface nnet_vector_scheduler_if #(
  parameter int WIDTH = 16
) ();

  logic [2*WIDTH-1:0] tdata;
  logic               tlast;
  logic               tvalid;
  logic               tready;

  modport master  (output tdata, tlast, tvalid, input tready);
  modport slave   (input tdata, tlast, tvalid, output tready);
  modport monitor (input tlast, tvalid, tready);

endinterface

// File: rtl/nnet_sched_watchdog.sv
// Hang watchdog: counts enabled cycles since the last load and pulses
// expire on the cycle the count reaches TIMEOUT (then saturates).
module nnet_sched_watchdog #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic load,
  input  logic enable,
  output logic expire
);

  localparam int            W     = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]  LIMIT = W'(TIMEOUT);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count and expiry pulse
  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (clear || load) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d  = cnt_q + W'(1);
      expire = (cnt_d == LIMIT);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/nnet_vector_scheduler.sv
// Admission controller for the NN vector datapath: admits whole vectors
// while credits remain, tracks completions on the snooped core output,
// and keeps sticky error flags and vector counters.
module nnet_vector_scheduler
  import nnet_sched_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int MAX_INFLIGHT = 3,
  parameter int TIMEOUT      = 65535,
  parameter int CNT_W        = 32
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              clear,
  input  logic                              enable,
  input  logic [15:0]                       pkt_size_out,
  nnet_vector_scheduler_if.slave            s,
  nnet_vector_scheduler_if.master           m,
  nnet_vector_scheduler_if.monitor          mon,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
  output logic                              idle,
  output logic                              hang_err,
  output logic                              len_err,
  output logic                              proto_err,
  output logic [CNT_W-1:0]                  vec_in_cnt,
  output logic [CNT_W-1:0]                  vec_out_cnt
);

  localparam int             IW    = $clog2(MAX_INFLIGHT + 1);
  localparam logic [IW-1:0]  MAX_V = IW'(MAX_INFLIGHT);

  state_t             state_q, state_d;
  logic [IW-1:0]      inflight_q, inflight_d;
  logic [CNT_W-1:0]   vin_q, vin_d, vout_q, vout_d;
  logic [15:0]        beat_q, beat_d;
  logic [ERR_W-1:0]   err_q, err_d;

  logic               pass, in_acc, in_first, out_beat, out_last;
  logic               wd_load, wd_en, wd_expire;
  logic [2*WIDTH-1:0] data_w;

  // Admission gate; clear also closes it so no beat is accepted into a
  // state that is being wiped this cycle
  always_comb begin
    pass = 1'b0;
    if (!clear) begin
      pass = (state_q == ACTIVE) ||
             (enable && (inflight_q < MAX_V) && !err_q[ERR_HANG]);
    end
  end

  assign data_w   = s.tdata;
  assign m.tdata  = data_w;
  assign m.tlast  = s.tlast;
  // reset_n gates the outputs directly so they fall without a clock edge
  assign m.tvalid = s.tvalid & pass & reset_n;
  assign s.tready = m.tready & pass & reset_n;

  assign in_acc   = s.tvalid & m.tready & pass;
  assign in_first = in_acc & (state_q == IDLE);
  assign out_beat = mon.tvalid & mon.tready;
  assign out_last = out_beat & mon.tlast;
  assign wd_en    = (inflight_q != '0);
  assign wd_load  = out_beat | ~wd_en;

  nnet_sched_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .load    (wd_load),
    .enable  (wd_en),
    .expire  (wd_expire)
  );

  // Next-state: framing FSM, credits, counters and sticky flags
  always_comb begin
    state_d    = state_q;
    inflight_d = inflight_q;
    vin_d      = vin_q;
    vout_d     = vout_q;
    beat_d     = beat_q;
    err_d      = err_q;
    if (clear) begin
      state_d    = IDLE;
      inflight_d = '0;
      vin_d      = '0;
      vout_d     = '0;
      beat_d     = '0;
      err_d      = '0;
    end else begin
      if (in_acc) state_d = s.tlast ? IDLE : ACTIVE;
      // completion with no credit outstanding must not underflow
      if (in_first && !(out_last && wd_en))       inflight_d = inflight_q + IW'(1);
      else if (!in_first && out_last && wd_en)    inflight_d = inflight_q - IW'(1);
      if (in_first) vin_d = vin_q + CNT_W'(1);
      if (out_beat) beat_d = out_last ? '0 : beat_q + 16'd1;
      if (out_last) begin
        vout_d = vout_q + CNT_W'(1);
        if ((pkt_size_out != '0) && (beat_q + 16'd1 != pkt_size_out)) err_d[ERR_LEN] = 1'b1;
        if (!wd_en) err_d[ERR_PROTO] = 1'b1;
      end
      if (wd_expire) err_d[ERR_HANG] = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      inflight_q <= '0;
      vin_q      <= '0;
      vout_q     <= '0;
      beat_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      vin_q      <= vin_d;
      vout_q     <= vout_d;
      beat_q     <= beat_d;
      err_q      <= err_d;
    end
  end

  assign inflight    = inflight_q;
  assign idle        = (state_q == IDLE) && (inflight_q == '0);
  assign hang_err    = err_q[ERR_HANG];
  assign len_err     = err_q[ERR_LEN];
  assign proto_err   = err_q[ERR_PROTO];
  assign vec_in_cnt  = vin_q;
  assign vec_out_cnt = vout_q;

endmodule
